// File: rtl/dmem_access_ctrl.sv
// rtl/dmem_access_ctrl.sv - load/store access controller for a word-addressed data memory
//
// Accepts one LB/LH/LW/LBU/LHU/SB/SH/SW request at a time, performs the memory
// access (read-modify-write for sub-word stores) and returns one response.
//
// Ports:
//   CLK, RST          clock, asynchronous active-high reset
//   req_valid/ready   request handshake; req_ready is high only in IDLE
//   req_op            operation code (LB=0 LH=1 LW=2 LBU=4 LHU=5 SB=8 SH=9 SW=10)
//   req_addr          byte address
//   req_wdata         store data (low byte/halfword for SB/SH)
//   resp_valid/ready  response handshake; response held until accepted
//   resp_rdata        extended load result, 0 for stores and errors
//   resp_err          misaligned, out-of-range or illegal request
//   mem_we, mem_re    memory write/read enables, never high together
//   mem_addr          word-aligned memory address
//   mem_wdata         full word to write
//   mem_rdata         combinational memory read data
module dmem_access_ctrl #(
    parameter int unsigned MEM_WORDS = 1048576
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [3:0]  req_op,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic        mem_we,
    output logic        mem_re,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RD   = 2'd1;
    localparam logic [1:0] ST_WR   = 2'd2;
    localparam logic [1:0] ST_RESP = 2'd3;

    localparam logic [3:0] OP_LB  = 4'd0;
    localparam logic [3:0] OP_LH  = 4'd1;
    localparam logic [3:0] OP_LW  = 4'd2;
    localparam logic [3:0] OP_LBU = 4'd4;
    localparam logic [3:0] OP_LHU = 4'd5;
    localparam logic [3:0] OP_SB  = 4'd8;
    localparam logic [3:0] OP_SH  = 4'd9;
    localparam logic [3:0] OP_SW  = 4'd10;

    localparam logic [31:0] MEM_WORDS_L = 32'(MEM_WORDS);

    logic [1:0]  state;
    logic [3:0]  op_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [31:0] word_buf;

    logic        req_legal;
    logic        req_misaligned;
    logic        req_out_of_range;
    logic        req_err;

    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] ld_result;
    logic [31:0] st_word;

    // Request decode, only consulted at the accept edge in IDLE.
    always_comb begin
        req_legal      = 1'b0;
        req_misaligned = 1'b0;
        case (req_op)
            OP_LB, OP_LBU, OP_SB: req_legal = 1'b1;
            OP_LH, OP_LHU, OP_SH: begin
                req_legal      = 1'b1;
                req_misaligned = req_addr[0];
            end
            OP_LW, OP_SW: begin
                req_legal      = 1'b1;
                req_misaligned = |req_addr[1:0];
            end
            default: req_legal = 1'b0;
        endcase
        req_out_of_range = {2'b00, req_addr[31:2]} >= MEM_WORDS_L;
        req_err          = !req_legal || req_misaligned || req_out_of_range;
    end

    // Load lane selection and extension from the live read data.
    always_comb begin
        case (addr_q[1:0])
            2'd0:    ld_byte = mem_rdata[7:0];
            2'd1:    ld_byte = mem_rdata[15:8];
            2'd2:    ld_byte = mem_rdata[23:16];
            default: ld_byte = mem_rdata[31:24];
        endcase
        ld_half = addr_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        case (op_q)
            OP_LB:   ld_result = {{24{ld_byte[7]}}, ld_byte};
            OP_LBU:  ld_result = {24'h0, ld_byte};
            OP_LH:   ld_result = {{16{ld_half[15]}}, ld_half};
            OP_LHU:  ld_result = {16'h0, ld_half};
            default: ld_result = mem_rdata;
        endcase
    end

    // Store word: buffered old word with the addressed lanes replaced.
    always_comb begin
        st_word = word_buf;
        case (op_q)
            OP_SB: begin
                case (addr_q[1:0])
                    2'd0:    st_word[7:0]   = wdata_q[7:0];
                    2'd1:    st_word[15:8]  = wdata_q[7:0];
                    2'd2:    st_word[23:16] = wdata_q[7:0];
                    default: st_word[31:24] = wdata_q[7:0];
                endcase
            end
            OP_SH: begin
                if (addr_q[1]) st_word[31:16] = wdata_q[15:0];
                else           st_word[15:0]  = wdata_q[15:0];
            end
            default: st_word = wdata_q;
        endcase
    end

    // Outputs decoded from state and registered request fields only.
    assign req_ready  = (state == ST_IDLE);
    assign resp_valid = (state == ST_RESP);
    assign mem_re     = (state == ST_RD);
    assign mem_we     = (state == ST_WR);
    assign mem_addr   = (mem_re || mem_we) ? {addr_q[31:2], 2'b00} : 32'h0;
    assign mem_wdata  = mem_we ? st_word : 32'h0;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state      <= ST_IDLE;
            op_q       <= 4'h0;
            addr_q     <= 32'h0;
            wdata_q    <= 32'h0;
            word_buf   <= 32'h0;
            resp_rdata <= 32'h0;
            resp_err   <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (req_valid) begin
                        op_q       <= req_op;
                        addr_q     <= req_addr;
                        wdata_q    <= req_wdata;
                        resp_rdata <= 32'h0;
                        if (req_err) begin
                            resp_err <= 1'b1;
                            state    <= ST_RESP;
                        end else if (req_op == OP_SW) begin
                            state <= ST_WR;
                        end else begin
                            state <= ST_RD;
                        end
                    end
                end
                ST_RD: begin
                    word_buf <= mem_rdata;
                    // Only legal ops reach RD; bit 3 marks SB/SH here.
                    if (op_q[3]) begin
                        state <= ST_WR;
                    end else begin
                        resp_rdata <= ld_result;
                        state      <= ST_RESP;
                    end
                end
                ST_WR: state <= ST_RESP;
                ST_RESP: begin
                    if (resp_ready) begin
                        resp_rdata <= 32'h0;
                        resp_err   <= 1'b0;
                        state      <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// tb/tb_dmem_access_ctrl.sv - self-checking bench for dmem_access_ctrl
module tb_dmem_access_ctrl;

    localparam int unsigned MEM_WORDS = 1048576;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [3:0]  req_op = 4'h0;
    logic [31:0] req_addr = 32'h0;
    logic [31:0] req_wdata = 32'h0;
    logic        resp_valid;
    logic        resp_ready = 1'b0;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        mem_we;
    logic        mem_re;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    logic [31:0] mem [0:255];
    logic [31:0] model_mem [0:255];

    int n_vec = 0;
    int n_mis = 0;

    always #5 CLK = ~CLK;

    assign mem_rdata = mem_re ? mem[mem_addr[9:2]] : 32'h0BAD0BAD;

    dmem_access_ctrl #(.MEM_WORDS(MEM_WORDS)) dut (
        .CLK(CLK), .RST(RST),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_rdata(resp_rdata), .resp_err(resp_err),
        .mem_we(mem_we), .mem_re(mem_re), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_req_ready"},  req_ready,  1);
        check({tag, "_resp_valid"}, resp_valid, 0);
        check({tag, "_resp_rdata"}, resp_rdata, 0);
        check({tag, "_resp_err"},   resp_err,   0);
        check({tag, "_mem_we"},     mem_we,     0);
        check({tag, "_mem_re"},     mem_re,     0);
        check({tag, "_mem_addr"},   mem_addr,   0);
        check({tag, "_mem_wdata"},  mem_wdata,  0);
    endtask

    // Reference behaviour straight from the access rules; also advances model_mem.
    task automatic model(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] wd,
                         output logic err, output logic [31:0] rd, output int lat,
                         output int nre, output int nwe);
        int unsigned off;
        int unsigned widx;
        logic [31:0] w;
        logic [31:0] mask;
        logic [7:0]  b;
        logic [15:0] h;
        bit legal;
        off   = addr % 4;
        widx  = addr / 4;
        legal = op inside {4'd0, 4'd1, 4'd2, 4'd4, 4'd5, 4'd8, 4'd9, 4'd10};
        err   = !legal
              || ((op == 4'd1 || op == 4'd5 || op == 4'd9) && (addr % 2 != 0))
              || ((op == 4'd2 || op == 4'd10) && off != 0)
              || widx >= MEM_WORDS;
        rd = 32'h0; lat = 1; nre = 0; nwe = 0;
        if (err) return;
        w = model_mem[widx % 256];
        b = 8'(w >> (8 * off));
        h = 16'(w >> (8 * off));
        case (op)
            4'd0:  begin rd = 32'($signed(b)); lat = 2; nre = 1; end
            4'd4:  begin rd = 32'(b);          lat = 2; nre = 1; end
            4'd1:  begin rd = 32'($signed(h)); lat = 2; nre = 1; end
            4'd5:  begin rd = 32'(h);          lat = 2; nre = 1; end
            4'd2:  begin rd = w;               lat = 2; nre = 1; end
            4'd8:  begin
                mask = 32'hFF << (8 * off);
                w = (w & ~mask) | ((wd & 32'hFF) << (8 * off));
                lat = 3; nre = 1; nwe = 1;
            end
            4'd9:  begin
                mask = 32'hFFFF << (8 * off);
                w = (w & ~mask) | ((wd & 32'hFFFF) << (8 * off));
                lat = 3; nre = 1; nwe = 1;
            end
            default: begin w = wd; lat = 2; nwe = 1; end
        endcase
        model_mem[widx % 256] = w;
    endtask

    // Drives one request, observes the memory side, commits writes at the edge.
    task automatic run_req(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] wd,
                           input int stall, output logic [31:0] rdata, output logic err,
                           output int lat, output int nre, output int nwe);
        logic [31:0] aligned;
        logic        pend;
        logic [7:0]  pidx;
        logic [31:0] pval;
        aligned = {addr[31:2], 2'b00};
        pend = 1'b0; pidx = 8'h0; pval = 32'h0;
        rdata = 32'h0; err = 1'b0;
        @(negedge CLK);
        check("idle_ready", req_ready, 1);
        req_valid = 1'b1; req_op = op; req_addr = addr; req_wdata = wd; resp_ready = 1'b0;
        @(posedge CLK);
        @(negedge CLK);
        req_valid = 1'b0; req_op = 4'($urandom); req_addr = $urandom; req_wdata = $urandom;
        lat = 1; nre = 0; nwe = 0;
        while (!resp_valid && lat < 8) begin
            check("re_we_exclusive", {31'h0, mem_re && mem_we}, 0);
            check("mem_addr", mem_addr, (mem_re || mem_we) ? aligned : 32'h0);
            if (mem_re) nre++;
            if (mem_we) begin nwe++; pend = 1'b1; pidx = mem_addr[9:2]; pval = mem_wdata; end
            @(posedge CLK);
            if (pend) mem[pidx] = pval;
            pend = 1'b0;
            @(negedge CLK);
            lat++;
        end
        if (resp_valid) begin
            rdata = resp_rdata;
            err   = resp_err;
            for (int s = 0; s < stall; s++) begin
                @(negedge CLK);
                check("stall_valid", resp_valid, 1);
                check("stall_rdata", resp_rdata, rdata);
            end
            resp_ready = 1'b1;
            @(posedge CLK);
            @(negedge CLK);
            resp_ready = 1'b0;
            check("post_hs_valid", resp_valid, 0);
        end
    endtask

    typedef struct {
        logic [3:0]  op;
        logic [31:0] addr;
        logic [31:0] wdata;
        bit          pre;
        logic [31:0] pre_val;
        logic [31:0] exp_rdata;
        logic        exp_err;
        int          exp_lat;
    } vec_t;

    vec_t tbl[$];

    initial begin
        logic [31:0] g_rd, m_rd;
        logic        g_err, m_err;
        int          g_lat, g_nre, g_nwe, m_lat, m_nre, m_nwe;
        logic [3:0]  op;
        logic [31:0] addr;
        logic [7:0]  pidx;
        logic [31:0] pval;

        tbl.push_back('{4'd2,  32'h10,       32'h0,        1, 32'hDEADBEEF, 32'hDEADBEEF, 1'b0, 2});
        tbl.push_back('{4'd0,  32'h13,       32'h0,        1, 32'h80FF7F01, 32'hFFFFFF80, 1'b0, 2});
        tbl.push_back('{4'd4,  32'h13,       32'h0,        0, 32'h0,        32'h00000080, 1'b0, 2});
        tbl.push_back('{4'd1,  32'h12,       32'h0,        0, 32'h0,        32'hFFFF80FF, 1'b0, 2});
        tbl.push_back('{4'd5,  32'h12,       32'h0,        0, 32'h0,        32'h000080FF, 1'b0, 2});
        tbl.push_back('{4'd8,  32'h21,       32'h000000AA, 1, 32'h11223344, 32'h0,        1'b0, 3});
        tbl.push_back('{4'd2,  32'h20,       32'h0,        0, 32'h0,        32'h1122AA44, 1'b0, 2});
        tbl.push_back('{4'd9,  32'h22,       32'h1234BEEF, 0, 32'h0,        32'h0,        1'b0, 3});
        tbl.push_back('{4'd2,  32'h20,       32'h0,        0, 32'h0,        32'hBEEFAA44, 1'b0, 2});
        tbl.push_back('{4'd10, 32'h7C,       32'h55AA33CC, 0, 32'h0,        32'h0,        1'b0, 2});
        tbl.push_back('{4'd4,  32'h7D,       32'h0,        0, 32'h0,        32'h00000033, 1'b0, 2});
        tbl.push_back('{4'd0,  32'h7E,       32'h0,        0, 32'h0,        32'hFFFFFFAA, 1'b0, 2});
        tbl.push_back('{4'd2,  32'h02,       32'h0,        0, 32'h0,        32'h0,        1'b1, 1});
        tbl.push_back('{4'd9,  32'h05,       32'hFFFF,     0, 32'h0,        32'h0,        1'b1, 1});
        tbl.push_back('{4'd3,  32'h10,       32'h0,        0, 32'h0,        32'h0,        1'b1, 1});
        tbl.push_back('{4'd2,  32'h00400000, 32'h0,        0, 32'h0,        32'h0,        1'b1, 1});

        for (int i = 0; i < 256; i++) begin
            mem[i] = $urandom;
            model_mem[i] = mem[i];
        end

        // Reset values, during and after reset.
        repeat (2) @(negedge CLK);
        check_reset_outputs("rst_held");
        RST = 1'b0;
        @(negedge CLK);
        check_reset_outputs("rst_released");

        // Directed table.
        foreach (tbl[i]) begin
            if (tbl[i].pre) begin
                mem[tbl[i].addr[9:2]] = tbl[i].pre_val;
                model_mem[tbl[i].addr[9:2]] = tbl[i].pre_val;
            end
            model(tbl[i].op, tbl[i].addr, tbl[i].wdata, m_err, m_rd, m_lat, m_nre, m_nwe);
            run_req(tbl[i].op, tbl[i].addr, tbl[i].wdata, 0, g_rd, g_err, g_lat, g_nre, g_nwe);
            check($sformatf("tbl%0d_rdata", i), g_rd, tbl[i].exp_rdata);
            check($sformatf("tbl%0d_err", i), {31'h0, g_err}, {31'h0, tbl[i].exp_err});
            check($sformatf("tbl%0d_lat", i), g_lat, tbl[i].exp_lat);
            check($sformatf("tbl%0d_nre", i), g_nre, m_nre);
            check($sformatf("tbl%0d_nwe", i), g_nwe, m_nwe);
            if (!m_err && tbl[i].addr < 32'd1024)
                check($sformatf("tbl%0d_memword", i), mem[tbl[i].addr[9:2]], model_mem[tbl[i].addr[9:2]]);
        end

        // Randomized requests against the reference model.
        for (int n = 0; n < 150; n++) begin
            case ($urandom_range(0, 9))
                0, 1, 2, 3, 4, 5, 6, 7: begin
                    case ($urandom_range(0, 7))
                        0: op = 4'd0; 1: op = 4'd1; 2: op = 4'd2; 3: op = 4'd4;
                        4: op = 4'd5; 5: op = 4'd8; 6: op = 4'd9; default: op = 4'd10;
                    endcase
                end
                default: op = 4'($urandom_range(0, 15));
            endcase
            if ($urandom_range(0, 9) == 0) addr = $urandom | 32'h00400000;
            else                           addr = $urandom_range(0, 1023);
            pval = $urandom;
            model(op, addr, pval, m_err, m_rd, m_lat, m_nre, m_nwe);
            run_req(op, addr, pval, $urandom_range(0, 2), g_rd, g_err, g_lat, g_nre, g_nwe);
            check($sformatf("rnd%0d_op%0d_a%h_rdata", n, op, addr), g_rd, m_rd);
            check($sformatf("rnd%0d_err", n), {31'h0, g_err}, {31'h0, m_err});
            check($sformatf("rnd%0d_lat", n), g_lat, m_lat);
            check($sformatf("rnd%0d_nre", n), g_nre, m_nre);
            check($sformatf("rnd%0d_nwe", n), g_nwe, m_nwe);
            if (!m_err && m_nwe != 0)
                check($sformatf("rnd%0d_memword", n), mem[addr[9:2]], model_mem[addr[9:2]]);
        end

        // SW with response stalled 5 cycles while a new request is held.
        model(4'd10, 32'h30, 32'hCAFEF00D, m_err, m_rd, m_lat, m_nre, m_nwe);
        @(negedge CLK);
        req_valid = 1'b1; req_op = 4'd10; req_addr = 32'h30; req_wdata = 32'hCAFEF00D; resp_ready = 1'b0;
        @(posedge CLK);
        @(negedge CLK);
        check("hold_we", mem_we, 1);
        check("hold_wdata", mem_wdata, 32'hCAFEF00D);
        pidx = mem_addr[9:2]; pval = mem_wdata;
        @(posedge CLK);
        if (mem_we) mem[pidx] = pval;
        @(negedge CLK);
        for (int s = 0; s < 5; s++) begin
            check("hold_resp_valid", resp_valid, 1);
            check("hold_req_ready", req_ready, 0);
            check("hold_no_access", {30'h0, mem_re, mem_we}, 0);
            check("hold_rdata", resp_rdata, 0);
            check("hold_err", resp_err, 0);
            @(negedge CLK);
        end
        resp_ready = 1'b1;
        @(posedge CLK);
        @(negedge CLK);
        resp_ready = 1'b0;
        check("rel_req_ready", req_ready, 1);
        check("rel_resp_valid", resp_valid, 0);
        @(posedge CLK);
        @(negedge CLK);
        req_valid = 1'b0;
        check("rel_second_accept", mem_we, 1);
        pidx = mem_addr[9:2]; pval = mem_wdata;
        @(posedge CLK);
        if (mem_we) mem[pidx] = pval;
        @(negedge CLK);
        check("rel_second_resp", resp_valid, 1);
        resp_ready = 1'b1;
        @(posedge CLK);
        @(negedge CLK);
        resp_ready = 1'b0;
        check("hold_memword", mem[12], model_mem[12]);

        // Reset during the WR cycle of SW 0x40.
        mem[16] = 32'hA5A5A5A5;
        model_mem[16] = 32'hA5A5A5A5;
        @(negedge CLK);
        req_valid = 1'b1; req_op = 4'd10; req_addr = 32'h40; req_wdata = 32'h12345678; resp_ready = 1'b1;
        @(posedge CLK);
        #2;
        check("rstwr_we_before", mem_we, 1);
        RST = 1'b1;
        #1;
        check_reset_outputs("rstwr");
        @(negedge CLK);
        req_valid = 1'b0;
        pidx = mem_addr[9:2]; pval = mem_wdata;
        @(posedge CLK);
        if (mem_we) mem[pidx] = pval;
        @(negedge CLK);
        RST = 1'b0;
        for (int s = 0; s < 3; s++) begin
            @(negedge CLK);
            check("rstwr_no_resp", resp_valid, 0);
            check("rstwr_idle", req_ready, 1);
        end
        check("rstwr_memword", mem[16], 32'hA5A5A5A5);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule

// File: doc/dmem_access_ctrl.md
# dmem_access_ctrl

Load/store access controller that issues requests to the word-addressed data memory on behalf of the CPU execute/memory stage. Accepts one byte, halfword or word load/store per request over a valid/ready handshake, and drives the memory's write enable, read enable, address and write-data lines. Performs sign/zero extension on loads and read-modify-write for sub-word stores, since the memory only supports full 32-bit words. Flags misaligned, out-of-range and illegal-opcode requests without touching memory.

## Interface
- MEM_WORDS, 1048576, number of 32-bit words in data memory; word index >= MEM_WORDS is out of range
- CLK  input  1  clock; all state updates on rising edge
- RST  input  1  asynchronous, active-high reset
- req_valid  input  1  request present
- req_ready  output  1  controller can accept; high only in IDLE
- req_op  input  4  0=LB, 1=LH, 2=LW, 4=LBU, 5=LHU, 8=SB, 9=SH, 10=SW; any other value is illegal
- req_addr  input  32  byte address
- req_wdata  input  32  store data; low byte/halfword used for SB/SH
- resp_valid  output  1  response present; held until accepted
- resp_ready  input  1  consumer accepts response
- resp_rdata  output  32  extended load result; 0 for stores and errors
- resp_err  output  1  misaligned, out-of-range or illegal op; no memory access made
- mem_we  output  1  memory write enable; write commits on the rising edge
- mem_re  output  1  memory read enable; read data is combinational
- mem_addr  output  32  word-aligned address {req_addr[31:2], 2'b00}
- mem_wdata  output  32  full word to write
- mem_rdata  input  32  memory read data; valid only while mem_re is high

## Operation
- States: IDLE, RD, WR, RESP.
- IDLE: req_ready=1. On req_valid at the rising edge, capture op, addr and wdata, then decode.
  - Error (illegal op; LH/LHU/SH with addr[0]=1; LW/SW with addr[1:0]!=0; addr[31:2] >= MEM_WORDS) -> RESP with resp_err=1.
  - Load or SB/SH -> RD.
  - SW -> WR.
- RD: mem_re=1 for exactly one cycle. mem_rdata is latched into the word buffer at the edge leaving RD.
  - Loads -> RESP.
  - SB/SH -> WR.
- WR: mem_we=1 for exactly one cycle.
  - SW: mem_wdata = captured wdata.
  - SB: buffer with byte lane addr[1:0] replaced by wdata[7:0].
  - SH: buffer with lanes addr[1]*2 +: 2 replaced by wdata[15:0].
  - Next state -> RESP.
- Byte lanes are little-endian: lane 0 = bits 7:0.
- Load extraction: select the byte or halfword by addr. LB/LH sign-extend; LBU/LHU zero-extend; LW passes the word through.
- RESP: resp_valid=1, with resp_rdata and resp_err stable. When resp_ready is high at the edge -> IDLE.
- mem_re and mem_we are never high together. Both are 0 in IDLE and RESP. mem_addr and mem_wdata are 0 when not in RD or WR.

## Timing
- Reset: state=IDLE, req_ready=1, resp_valid=0, resp_rdata=0, resp_err=0, mem_we=0, mem_re=0, mem_addr=0, mem_wdata=0, word buffer=0.
- All outputs are registered or decoded from state only. There is no combinational path from req_* or resp_ready to any output.
- Latency is measured from the accept edge to the first cycle with resp_valid high:
  - Loads: 2 cycles.
  - SW: 2 cycles.
  - SB/SH: 3 cycles.
  - Errors: 1 cycle.
- Back-to-back: the next request is accepted no earlier than 1 cycle after the response handshake, because req_ready is low in RESP. Maximum throughput is one load per 3 cycles.
- resp_valid held with resp_ready low: state, resp_rdata and resp_err are frozen indefinitely.
- RST asserted in WR: mem_we drops immediately (asynchronous). The write does not commit unless an edge occurred before RST rose. The request is dropped and no response is issued.
- RST asserted in RD or RESP: the request and any pending response are discarded; outputs go to reset values.
- req_valid while not in IDLE is ignored. The requester must hold it until req_ready.

## Test plan
- LW addr 0x10, memory word 4 = 0xDEADBEEF -> mem_re one cycle at mem_addr 0x10, then resp_rdata=0xDEADBEEF, resp_err=0, 2 cycles after accept.
- LB at 0x13 and LBU at 0x13 on word 0x80FF7F01 -> 0xFFFFFF80 and 0x00000080. LH at 0x12 -> 0xFFFF80FF; LHU at 0x12 -> 0x000080FF.
- SB addr 0x21, wdata 0x000000AA, word 8 = 0x11223344 -> RD then WR, mem_wdata=0x1122AA44, resp after 3 cycles. A following LW 0x20 returns 0x1122AA44.
- LW at 0x02, SH at 0x05, req_op=3, and LW at MEM_WORDS*4 -> each gives resp_err=1, resp_rdata=0, after 1 cycle, with mem_re=mem_we=0 throughout.
- Hold resp_ready low for 5 cycles after an SW, with req_valid high -> resp_valid is held, req_ready stays 0, and no second access occurs. On release, the next request is accepted 1 cycle later.
- Assert RST during the WR cycle of SW 0x40 = 0x12345678 -> mem_we falls immediately, word 16 is unchanged, and all outputs return to reset values.
